ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
Round-robin AHB-Lite multi-master arbiter. It shares one AHB address/data path between NUM_MASTERS requesters and drives HGRANT, HMASTER and HMASTLOCK. It honours fixed-length bursts and locked sequences, and parks the bus on a default master when idle. It sits beside the master-side address/write-data mux and steers that mux through HMASTER. Address and data widths come from ahb_pkg.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16).
DEFAULT_MASTER, 0, master that is granted when nobody requests and out of reset.
MASTER_ID_W, $clog2(NUM_MASTERS), width of HMASTER; derived, not overridden.

Ports:
HCLK  in  1  bus clock, rising edge.
HRESETn  in  1  asynchronous, active-low reset.
HBUSREQ  in  NUM_MASTERS  per-master bus request.
HLOCK  in  NUM_MASTERS  per-master locked-sequence request.
HTRANS  in  2  muxed transfer type of the current address-phase owner.
HBURST  in  3  muxed burst type of the current owner.
HREADY  in  1  bus-wide ready; phases advance only when this is 1.
HGRANT  out  NUM_MASTERS  one-hot grant.
HMASTER  out  MASTER_ID_W  index of the address-phase owner; drives the mux select.
HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Clock and reset: single clock HCLK. Reset HRESETn is asynchronous and active-low. On reset, every output takes its reset value immediately, including mid-burst:
  - HGRANT = one-hot(DEFAULT_MASTER)
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - RR pointer = DEFAULT_MASTER
  - state = ARB, beat counter = 0
- Update rule: all registers update only on HCLK edges with HREADY=1. When HREADY=0, everything holds.
- Pick function: search HBUSREQ starting at pointer+1, modulo NUM_MASTERS. The first set bit wins. If no request is set, the winner is DEFAULT_MASTER. When a new grant is registered, the pointer is set to the winner.
- Latency: a request seen at edge N produces HGRANT at edge N (registered, visible cycle N+1). HMASTER <= index(HGRANT) at the next HREADY edge, so HMASTER lags HGRANT by one accepted address phase.
- HMASTLOCK <= HLOCK[granted] on the same edge as the HMASTER update.
- State ARB:
  - Grant re-picks every HREADY edge.
  - If the owner is accepted with HTRANS=NONSEQ and a fixed burst (WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16):
    - load rem = beats-1 (3, 7 or 15)
    - go to BURST
    - hold the grant on that edge
  - If the owner is accepted with HLOCK[owner]=1: go to LOCKED and hold the grant.
  - LOCKED takes precedence when both apply; the burst count still runs and is ignored.
- State BURST:
  - Grant is held.
  - HREADY & SEQ: rem decrements. BUSY does not decrement.
  - On the edge where rem goes 2->1: re-pick the grant (new HGRANT visible during the final address beat) and return to ARB.
  - HREADY & HTRANS ∈ {IDLE, NONSEQ}: early termination; return to ARB with a re-pick on the same edge.
- State LOCKED:
  - Grant is held regardless of other requests.
  - HREADY & HLOCK[owner]=0: re-pick on that edge and return to ARB.
- SINGLE and INCR (undefined length) bursts: no hold; arbitration proceeds every edge.
- Simultaneous events: a current grantee that still requests while no other master requests keeps the grant; the pointer is unchanged.
- Not supported: SPLIT/RETRY and HSPLIT.

Decomposition:
- ahb_pkg additions:
  - HTRANS_T enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
  - HBURST_T enum: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7
  - function burst_beats(HBURST_T): returns 0 for SINGLE and INCR, otherwise 4/8/16
- Sub-module: ahb_rr_pick, combinational. Inputs: request vector, pointer. Outputs: one-hot winner, index, any_req.

Test Plan:
1. Reset: HRESETn=0 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0. Release reset with HBUSREQ=0 -> HGRANT stays 0001.
2. HBUSREQ=0110, HREADY=1, SINGLE NONSEQ every cycle -> HGRANT sequence 0010, 0100, 0010, …; HMASTER sequence 1, 2, 1 lags HGRANT by one cycle.
3. Master 2 INCR4 with HBUSREQ=1100 and HREADY=0 for one cycle during beat 2:
   - HGRANT stays 0100 until the edge accepting beat 3
   - then HGRANT=1000
   - HMASTER=3 after beat 4 is accepted
4. Master 1 with HLOCK=1 over 3 SINGLE transfers, HBUSREQ=1011:
   - HGRANT stays 0010 throughout
   - HMASTLOCK=1 aligned with HMASTER=1
   - drop HLOCK -> grant moves to master 3 on the next HREADY edge
5. Master 0 INCR8 terminated by IDLE after 2 beats, HBUSREQ[3]=1 -> return to ARB and HGRANT=1000 on the same edge.
6. HRESETn pulled low mid-INCR16 -> outputs take reset values before the next HCLK edge, and the counter clears.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the bus arbiter.
//   HTRANS_T    - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST_T    - burst type (SINGLE, INCR, fixed-length WRAP/INCR bursts)
//   arb_state_t - arbiter hold state (free arbitration, fixed burst, locked)
//   burst_beats - beat count of a fixed-length burst, 0 for SINGLE/INCR
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } HTRANS_T;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } HBURST_T;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      BURST  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   // Undefined-length bursts (SINGLE, INCR) report 0: they never hold the grant.
   function automatic logic [4:0] burst_beats(HBURST_T burst);
      case (burst)
         WRAP4, INCR4:   return 5'd4;
         WRAP8, INCR8:   return 5'd8;
         WRAP16, INCR16: return 5'd16;
         default:        return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational round-robin search.
//   req     - request vector, one bit per master
//   ptr     - index of the last winner; the search starts at ptr+1
//   winner  - one-hot winner (all zero when nothing is requested)
//   idx     - index of the winner (0 when nothing is requested)
//   any_req - at least one request is set; the caller applies bus parking
module ahb_rr_pick #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] winner,
   output logic [W-1:0] idx,
   output logic         any_req
);

   logic         found;
   int           cand;
   logic [W-1:0] cand_idx;

   always_comb begin
      winner   = '0;
      idx      = '0;
      any_req  = |req;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Offsets 1..N visit every master once, ending on ptr itself, so the
      // current owner only wins again when nobody else asks.
      for (int i = 1; i <= N; i++) begin
         cand = int'(ptr) + i;
         if (cand >= N) cand = cand - N;
         cand_idx = W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
      if (found) winner[idx] = 1'b1;
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-Lite arbiter with fixed-burst and
// locked-sequence hold, parking on DEFAULT_MASTER when idle.
//   HCLK, HRESETn - clock (rising edge), asynchronous active-low reset
//   HBUSREQ       - per-master bus request
//   HLOCK         - per-master locked-sequence request
//   HTRANS/HBURST - transfer and burst type of the current address-phase owner
//   HREADY        - bus ready; every register advances only when it is 1
//   HGRANT        - registered one-hot grant
//   HMASTER       - address-phase owner, one accepted phase behind HGRANT
//   HMASTLOCK     - the current address phase is locked
module ahb_bus_arbiter
   import ahb_pkg::*;
#(
   parameter  int NUM_MASTERS    = 4,
   parameter  int DEFAULT_MASTER = 0,
   localparam int MASTER_ID_W    = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MASTER_ID_W-1:0] HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [MASTER_ID_W-1:0] DEF_IDX = MASTER_ID_W'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   arb_state_t             state_reg, state_next;
   logic [3:0]             rem_reg, rem_next;
   logic [NUM_MASTERS-1:0] grant_reg, grant_next;
   logic [MASTER_ID_W-1:0] grant_idx_reg, grant_idx_next;
   logic [MASTER_ID_W-1:0] ptr_reg, ptr_next;
   logic [MASTER_ID_W-1:0] master_reg;
   logic                   mastlock_reg;

   logic [NUM_MASTERS-1:0] pick_winner;
   logic [MASTER_ID_W-1:0] pick_idx;
   logic                   pick_any;
   logic                   repick;
   logic                   owner_lock;
   HTRANS_T                trans;
   logic [4:0]             beats;

   ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
      .req     (HBUSREQ),
      .ptr     (ptr_reg),
      .winner  (pick_winner),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   always_comb begin
      state_next     = state_reg;
      rem_next       = rem_reg;
      grant_next     = grant_reg;
      grant_idx_next = grant_idx_reg;
      ptr_next       = ptr_reg;
      repick         = 1'b0;
      // Hold decisions look at the owner of the address phase on the bus.
      owner_lock     = HLOCK[master_reg];
      trans          = HTRANS_T'(HTRANS);
      beats          = burst_beats(HBURST_T'(HBURST));

      case (state_reg)
         ARB: begin
            // The counter loads even when a lock wins; it is then ignored.
            if (trans == NONSEQ && beats != 5'd0) rem_next = 4'(beats - 5'd1);
            if (owner_lock)                            state_next = LOCKED;
            else if (trans == NONSEQ && beats != 5'd0) state_next = BURST;
            else                                       repick = 1'b1;
         end
         BURST: begin
            case (trans)
               SEQ: begin
                  rem_next = rem_reg - 4'd1;
                  // Release one beat early so the next owner is granted
                  // while the final address beat is on the bus.
                  if (rem_reg == 4'd2) begin
                     repick     = 1'b1;
                     state_next = ARB;
                  end
               end
               IDLE, NONSEQ: begin
                  repick     = 1'b1;
                  state_next = ARB;
                  rem_next   = 4'd0;
               end
               default: ;
            endcase
         end
         LOCKED: begin
            if (trans == SEQ && rem_reg != 4'd0) rem_next = rem_reg - 4'd1;
            if (!owner_lock) begin
               repick     = 1'b1;
               state_next = ARB;
               rem_next   = 4'd0;
            end
         end
         default: begin
            state_next = ARB;
            rem_next   = 4'd0;
         end
      endcase

      if (repick) begin
         grant_next     = pick_any ? pick_winner : DEF_ONEHOT;
         grant_idx_next = pick_any ? pick_idx : DEF_IDX;
         ptr_next       = grant_idx_next;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg     <= ARB;
         rem_reg       <= 4'd0;
         grant_reg     <= DEF_ONEHOT;
         grant_idx_reg <= DEF_IDX;
         ptr_reg       <= DEF_IDX;
         master_reg    <= DEF_IDX;
         mastlock_reg  <= 1'b0;
      end else if (HREADY) begin
         state_reg     <= state_next;
         rem_reg       <= rem_next;
         grant_reg     <= grant_next;
         grant_idx_reg <= grant_idx_next;
         ptr_reg       <= ptr_next;
         master_reg    <= grant_idx_reg;
         mastlock_reg  <= HLOCK[grant_idx_reg];
      end
   end

   assign HGRANT    = grant_reg;
   assign HMASTER   = master_reg;
   assign HMASTLOCK = mastlock_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
module tb_ahb_bus_arbiter;
   import ahb_pkg::*;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic         clk;
   logic         rstn;
   logic [N-1:0] hbusreq;
   logic [N-1:0] hlock;
   logic [1:0]   htrans;
   logic [2:0]   hburst;
   logic         hready;
   logic [N-1:0] hgrant;
   logic [1:0]   hmaster;
   logic         hmastlock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
      .HCLK      (clk),
      .HRESETn   (rstn),
      .HBUSREQ   (hbusreq),
      .HLOCK     (hlock),
      .HTRANS    (htrans),
      .HBURST    (hburst),
      .HREADY    (hready),
      .HGRANT    (hgrant),
      .HMASTER   (hmaster),
      .HMASTLOCK (hmastlock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Grant is kept as a master number; hold reasons are "in a locked
   // sequence" and "inside a fixed burst, counting SEQ beats seen so far".
   int m_gnt, m_ptr, m_mst;
   bit m_lck, m_locked, m_in_burst;
   int m_beats, m_seqs;

   function automatic int rr_pick(int ptr, logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (ptr + k) % N;
         if (req[c]) return c;
      end
      return DEF;
   endfunction

   function automatic int fixed_len(logic [2:0] b);
      int len;
      case (b)
         3'd2, 3'd3: len = 4;
         3'd4, 3'd5: len = 8;
         3'd6, 3'd7: len = 16;
         default:    len = 0;
      endcase
      return len;
   endfunction

   always @(posedge clk or negedge rstn) begin : model
      bit repick;
      bit own_lock;
      int nb;
      int w;
      if (!rstn) begin
         m_gnt <= DEF; m_ptr <= DEF; m_mst <= DEF; m_lck <= 1'b0;
         m_locked <= 1'b0; m_in_burst <= 1'b0; m_beats <= 0; m_seqs <= 0;
      end else if (hready) begin
         repick   = 1'b0;
         own_lock = hlock[m_mst];
         nb       = fixed_len(hburst);
         if (m_locked) begin
            if (!own_lock) begin repick = 1'b1; m_locked <= 1'b0; end
         end else if (m_in_burst) begin
            if (htrans == 2'd3) begin
               // Released when the second-to-last beat is accepted.
               if (m_seqs + 1 == m_beats - 2) begin repick = 1'b1; m_in_burst <= 1'b0; end
               m_seqs <= m_seqs + 1;
            end else if (htrans == 2'd0 || htrans == 2'd2) begin
               repick = 1'b1; m_in_burst <= 1'b0;
            end
         end else begin
            if (own_lock) m_locked <= 1'b1;
            else if (htrans == 2'd2 && nb != 0) begin
               m_in_burst <= 1'b1; m_beats <= nb; m_seqs <= 0;
            end else repick = 1'b1;
         end
         if (repick) begin
            w = rr_pick(m_ptr, hbusreq);
            m_gnt <= w;
            m_ptr <= w;
         end
         m_mst <= m_gnt;
         m_lck <= hlock[m_gnt];
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("hgrant_vs_model", int'(hgrant), 1 << m_gnt);
      chk("hmaster_vs_model", int'(hmaster), m_mst);
      chk("hmastlock_vs_model", int'(hmastlock), int'(m_lck));
   end

   // ---------------- directed stimulus ----------------
   task automatic step(logic [N-1:0] req, logic [N-1:0] lk, logic [1:0] tr,
                       logic [2:0] bu, logic rdy);
      hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d req=%b lock=%b trans=%0d burst=%0d ready=%b -> grant=%b master=%0d mastlock=%b",
               cyc, req, lk, tr, bu, rdy, hgrant, hmaster, hmastlock);
   endtask

   localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] B_SGL = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

   initial begin
      rstn = 1'b0;
      hbusreq = '0; hlock = '0; htrans = T_IDLE; hburst = B_SGL; hready = 1'b1;

      // 1. reset values and parking
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", int'(hgrant), 'b0001);
      chk("rst_master", int'(hmaster), 0);
      chk("rst_mastlock", int'(hmastlock), 0);
      rstn = 1'b1;
      step(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1);
      chk("park_grant", int'(hgrant), 'b0001);

      // 2. round robin between masters 1 and 2, HMASTER one phase behind
      step(4'b0110, 4'b0000, T_NSEQ, B_SGL, 1'b1);
      chk("rr1_grant", int'(hgrant), 'b0010); chk("rr1_master", int'(hmaster), 0);
      step(4'b0110, 4'b0000, T_NSEQ, B_SGL, 1'b1);
      chk("rr2_grant", int'(hgrant), 'b0100); chk("rr2_master", int'(hmaster), 1);
      step(4'b0110, 4'b0000, T_NSEQ, B_SGL, 1'b1);
      chk("rr3_grant", int'(hgrant), 'b0010); chk("rr3_master", int'(hmaster), 2);
      step(4'b0110, 4'b0000, T_NSEQ, B_SGL, 1'b1);
      chk("rr4_grant", int'(hgrant), 'b0100); chk("rr4_master", int'(hmaster), 1);

      // 3. master 2 INCR4 with a wait state in beat 2
      step(4'b0100, 4'b0000, T_IDLE, B_SGL, 1'b1);
      chk("b4_setup_master", int'(hmaster), 2);
      step(4'b1100, 4'b0000, T_NSEQ, B_INCR4, 1'b1);
      chk("b4_beat1_grant", int'(hgrant), 'b0100);
      step(4'b1100, 4'b0000, T_SEQ, B_INCR4, 1'b0);
      chk("b4_wait_grant", int'(hgrant), 'b0100);
      step(4'b1100, 4'b0000, T_SEQ, B_INCR4, 1'b1);
      chk("b4_beat2_grant", int'(hgrant), 'b0100);
      step(4'b1100, 4'b0000, T_SEQ, B_INCR4, 1'b1);
      chk("b4_beat3_grant", int'(hgrant), 'b1000); chk("b4_beat3_master", int'(hmaster), 2);
      step(4'b1100, 4'b0000, T_SEQ, B_INCR4, 1'b1);
      chk("b4_beat4_master", int'(hmaster), 3); chk("b4_beat4_grant", int'(hgrant), 'b0100);

      // 4. master 1 locked sequence
      step(4'b0010, 4'b0010, T_IDLE, B_SGL, 1'b1);
      step(4'b0010, 4'b0010, T_IDLE, B_SGL, 1'b1);
      chk("lk_setup_master", int'(hmaster), 1); chk("lk_setup_mastlock", int'(hmastlock), 1);
      for (int i = 0; i < 3; i++) begin
         step(4'b1011, 4'b0010, T_NSEQ, B_SGL, 1'b1);
         chk("lk_hold_grant", int'(hgrant), 'b0010);
         chk("lk_hold_mastlock", int'(hmastlock), 1);
      end
      step(4'b1011, 4'b0000, T_NSEQ, B_SGL, 1'b1);
      chk("lk_drop_grant", int'(hgrant), 'b1000); chk("lk_drop_mastlock", int'(hmastlock), 0);

      // 5. master 0 INCR8 cut short by IDLE
      step(4'b0001, 4'b0000, T_IDLE, B_SGL, 1'b1);
      step(4'b0001, 4'b0000, T_IDLE, B_SGL, 1'b1);
      chk("et_setup_master", int'(hmaster), 0);
      step(4'b1001, 4'b0000, T_NSEQ, B_INCR8, 1'b1);
      chk("et_beat1_grant", int'(hgrant), 'b0001);
      step(4'b1001, 4'b0000, T_SEQ, B_INCR8, 1'b1);
      chk("et_beat2_grant", int'(hgrant), 'b0001);
      step(4'b1001, 4'b0000, T_IDLE, B_INCR8, 1'b1);
      chk("et_idle_grant", int'(hgrant), 'b1000);

      // 6. asynchronous reset in the middle of an INCR16
      step(4'b1000, 4'b0000, T_IDLE, B_SGL, 1'b1);
      step(4'b1000, 4'b0000, T_IDLE, B_SGL, 1'b1);
      chk("ar_setup_master", int'(hmaster), 3);
      step(4'b1001, 4'b0000, T_NSEQ, B_INCR16, 1'b1);
      step(4'b1001, 4'b0000, T_SEQ, B_INCR16, 1'b1);
      step(4'b1001, 4'b0000, T_SEQ, B_INCR16, 1'b1);
      chk("ar_burst_grant", int'(hgrant), 'b1000);
      #2 rstn = 1'b0;
      #1;
      chk("ar_async_grant", int'(hgrant), 'b0001);
      chk("ar_async_master", int'(hmaster), 0);
      chk("ar_async_mastlock", int'(hmastlock), 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step(4'b1000, 4'b0000, T_SEQ, B_INCR16, 1'b1);
      chk("ar_cleared_grant", int'(hgrant), 'b1000);

      step(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1);
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
